// File: rtl/dcache_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_responder_if
// Description : Bundles the requester-side (ufp) and line-memory-side (dfp)
//               signals of the data cache. The slave modport is the cache's
//               view; the master modport is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_responder_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          ufp_addr;
    logic [3:0]           ufp_rmask;
    logic [3:0]           ufp_wmask;
    logic [31:0]          ufp_wdata;
    logic [31:0]          ufp_rdata;
    logic                 ufp_resp;

    logic [31:0]          dfp_addr;
    logic                 dfp_read;
    logic                 dfp_write;
    logic [LINE_BITS-1:0] dfp_wdata;
    logic [LINE_BITS-1:0] dfp_rdata;
    logic                 dfp_resp;

    modport slave (
        input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        output ufp_rdata, ufp_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    modport master (
        output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        input  ufp_rdata, ufp_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module      : dcache_responder
// Description : Blocking, direct-mapped, write-back, write-allocate data
//               cache. Responds to single-word requests and fetches/evicts
//               whole lines over the line memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_responder #(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256
) (
    input  logic              clk,
    input  logic              rst,
    dcache_responder_if.slave bus
);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int TAG_W    = 32 - SET_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;

    // Latched request; the byte-offset bits within a word are never needed.
    logic [31:2]          r_addr;
    logic [3:0]           r_wmask;
    logic [31:0]          r_wdata;

    logic [NUM_SETS-1:0]  r_valid;
    logic [NUM_SETS-1:0]  r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_SETS];
    logic [LINE_BITS-1:0] r_data [NUM_SETS];

    logic [SET_W-1:0]     w_set;
    logic [TAG_W-1:0]     w_tag;
    logic [WORD_W-1:0]    w_word;
    logic                 w_hit;
    logic                 w_req;
    logic [LINE_BITS-1:0] w_line;
    logic [LINE_BITS-1:0] w_merged_line;

    assign w_set  = r_addr[OFFSET_W +: SET_W];
    assign w_tag  = r_addr[31 -: TAG_W];
    assign w_word = r_addr[2 +: WORD_W];
    assign w_line = r_data[w_set];
    assign w_hit  = r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_req  = (|bus.ufp_rmask) || (|bus.ufp_wmask);

    // Line image after applying the latched write bytes to the addressed word.
    always_comb begin
        w_merged_line = w_line;
        for (int i = 0; i < 4; i++) begin
            if (r_wmask[i]) begin
                w_merged_line[{w_word, 2'(i), 3'b000} +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_req) w_next_state = S_COMPARE;
            S_COMPARE: begin
                if (w_hit)                             w_next_state = S_IDLE;
                else if (r_valid[w_set] && r_dirty[w_set]) w_next_state = S_WRITEBACK;
                else                                   w_next_state = S_ALLOCATE;
            end
            S_WRITEBACK: if (bus.dfp_resp) w_next_state = S_ALLOCATE;
            S_ALLOCATE:  if (bus.dfp_resp) w_next_state = S_COMPARE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Output decode; everything not driven by the current state stays at zero.
    always_comb begin
        bus.ufp_resp  = 1'b0;
        bus.ufp_rdata = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        bus.dfp_addr  = '0;
        bus.dfp_wdata = '0;
        case (r_state)
            S_COMPARE: begin
                if (w_hit) begin
                    bus.ufp_resp  = 1'b1;
                    bus.ufp_rdata = w_line[{w_word, 5'b00000} +: 32];
                end
            end
            S_WRITEBACK: begin
                bus.dfp_write = 1'b1;
                bus.dfp_addr  = {r_tag[w_set], w_set, {OFFSET_W{1'b0}}};
                bus.dfp_wdata = w_line;
            end
            S_ALLOCATE: begin
                bus.dfp_read = 1'b1;
                bus.dfp_addr = {w_tag, w_set, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    // Capture the request when it is accepted out of IDLE.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_addr  <= bus.ufp_addr[31:2];
            r_wmask <= bus.ufp_wmask;
            r_wdata <= bus.ufp_wdata;
        end
    end

    // Valid/dirty bookkeeping; these are the only storage bits that need reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (r_state == S_COMPARE && w_hit && (|r_wmask)) begin
                r_dirty[w_set] <= 1'b1;
            end else if (r_state == S_WRITEBACK && bus.dfp_resp) begin
                r_dirty[w_set] <= 1'b0;
            end else if (r_state == S_ALLOCATE && bus.dfp_resp) begin
                r_valid[w_set] <= 1'b1;
                r_dirty[w_set] <= 1'b0;
            end
        end
    end

    // Tag and line storage: filled on allocate, byte-merged on a write hit.
    always_ff @(posedge clk) begin
        if (r_state == S_ALLOCATE && bus.dfp_resp) begin
            r_data[w_set] <= bus.dfp_rdata;
            r_tag[w_set]  <= w_tag;
        end else if (r_state == S_COMPARE && w_hit && (|r_wmask)) begin
            r_data[w_set] <= w_merged_line;
        end
    end
endmodule
`default_nettype wire

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of the core's cache request interface: addr, rmask, wmask, wdata, with the request valid whenever either mask is nonzero.
- Blocking, direct-mapped, write-back, write-allocate data cache. Sits between the LSQ (requester) and the 256-bit line memory port.
- Address split: tag [31:9], set [8:5], offset [4:0]. 16 sets of 32-byte lines.

Parameters:
- NUM_SETS, 16, number of lines; set index width = clog2(NUM_SETS) = 4.
- LINE_BITS, 256, line width in bits; 8 words per line.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ufp_addr  in  32  request byte address; bits [1:0] ignored.
- ufp_rmask  in  4  read byte mask; nonzero = read request.
- ufp_wmask  in  4  write byte mask; nonzero = write request.
- ufp_wdata  in  32  write data, byte lanes per wmask.
- ufp_rdata  out  32  read word, valid while ufp_resp=1.
- ufp_resp  out  1  single-cycle completion pulse.
- dfp_addr  out  32  line address, bits [4:0] = 0.
- dfp_read  out  1  line fill request, held until dfp_resp.
- dfp_write  out  1  line writeback request, held until dfp_resp.
- dfp_wdata  out  256  victim line data.
- dfp_rdata  in  256  fill data, valid with dfp_resp.
- dfp_resp  in  1  memory completion pulse.

Behaviour:
- Storage (flops, per set): valid, dirty, 23-bit tag, 256-bit data.
- Reset (async, any state): all valid/dirty bits = 0, FSM = IDLE, all outputs = 0. Data and tag contents are don't-care.
- Reset mid-miss drops dfp_read/dfp_write immediately. A dfp_resp that arrives while in IDLE is ignored.
- Requester protocol: hold addr, masks and wdata stable until ufp_resp. The block also latches the request at acceptance. The cycle after ufp_resp, the requester either deasserts both masks or presents a new request.
- rmask and wmask both nonzero: ufp_rdata returns the pre-write word and the write is applied.
- IDLE: if rmask|wmask != 0, latch the request and go to COMPARE; otherwise stay.
- COMPARE: hit = valid[set] && tag[set] == req tag.
  - Hit: ufp_resp = 1 this cycle. ufp_rdata = line word addr[4:2]. Write bytes are merged per wmask at the clock edge and dirty is set. Next state IDLE.
  - Miss with victim clean or invalid: go to ALLOCATE, ufp_resp = 0.
  - Miss with victim valid and dirty: go to WRITEBACK.
- WRITEBACK: dfp_write = 1, dfp_addr = {victim tag, set, 5'b0}, dfp_wdata = victim line. On dfp_resp, clear dirty and go to ALLOCATE.
- ALLOCATE: dfp_read = 1, dfp_addr = {req tag, set, 5'b0}. On dfp_resp, write dfp_rdata into the line, set valid = 1, dirty = 0, tag = req tag, and return to COMPARE, where the request hits.
- dfp_read and dfp_write are never asserted together. Both are 0 in IDLE and COMPARE.
- Latency, counted from the request visible in IDLE at cycle 0:
  - Hit: ufp_resp in cycle 1.
  - Clean miss: ufp_resp one cycle after the fill dfp_resp.
  - Dirty miss: writeback, then fill, then COMPARE.
- Throughput: at most one request per 2 cycles.
- Byte lanes: wmask[i] writes wdata[8i+7:8i] into byte 4*addr[4:2]+i of the line. rdata always returns the full word; the requester selects bytes.
- Write to a missing line: allocate first, then merge in COMPARE. There is no write-around.

Test Plan:
- After reset, read 0x0000_0040 (rmask=4'hF) → dfp_read with dfp_addr 0x0000_0040; return line with word0 = 0x1122_3344 → ufp_resp one cycle later, rdata 0x1122_3344. Repeat read → ufp_resp in cycle 1, no dfp activity.
- Write 0x0000_0044 wmask=4'b0110 wdata 0xAABB_CCDD to a resident line holding 0x5566_7788 → hit in cycle 1. Subsequent read returns 0x55BB_CC88.
- Dirty line in set 2 (tag 0), then read 0x0000_0240 (tag 1, same set) → dfp_write with dfp_addr 0x0000_0040 and the merged line, then dfp_read at 0x0000_0240, then ufp_resp. dfp_read and dfp_write are never high together.
- Assert rst while dfp_read=1 in ALLOCATE, then send dfp_resp after release → outputs 0 immediately, resp ignored, next read of the same address misses again.
- Back-to-back hits: three reads to resident lines with masks held until resp → ufp_resp pulses at cycles 1, 3 and 5, each exactly one cycle wide.
- rmask=4'hF and wmask=4'h1 with wdata 0x0000_00EE on a resident word 0x1234_5678 → rdata 0x1234_5678, and the line now holds 0x1234_56EE.
